// File: rtl/mm_pkg.sv
// Shared types and constants for the streaming matrix multiplier.
package mm_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StCheck,
      StCompute
   } mm_state_e;

   localparam int unsigned MAXD_DEFAULT = 4;
   localparam int unsigned DIM_W        = $clog2(MAXD_DEFAULT + 1);

   // Bit positions in the legality reason vector; any set bit makes a pair illegal.
   localparam int unsigned RSN_RAGGED   = 0;
   localparam int unsigned RSN_OVERSIZE = 1;
   localparam int unsigned RSN_MISMATCH = 2;
   localparam int unsigned RSN_W        = 3;

   function automatic int unsigned dim_w(input int unsigned maxd);
      return $clog2(maxd + 1);
   endfunction

endpackage

// File: rtl/mm_stream_param_dot.sv
// Signed MAXD-term dot product over the first len_i terms.
// MM_SERIAL_MAC_EN selects a single multiply-accumulate; otherwise fully parallel.
module mm_dot_unit
   import mm_pkg::*;
#(
   parameter int unsigned DW   = 8,
   parameter int unsigned MAXD = 4,
   parameter int unsigned OW   = 2*DW + $clog2(MAXD) + 1
) (
`ifdef MM_SERIAL_MAC_EN
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
`endif
   input  logic [MAXD*DW-1:0]        a_i,
   input  logic [MAXD*DW-1:0]        b_i,
   input  logic [dim_w(MAXD)-1:0]    len_i,
   output logic signed [OW-1:0]      sum_o,
   output logic                      valid_o
);

   localparam int unsigned CNT_W = dim_w(MAXD);

   logic signed [2*DW-1:0] prod;

`ifdef MM_SERIAL_MAC_EN
   logic [CNT_W-1:0]   k_q;
   logic               run_q;
   logic               vld_q;
   logic signed [OW-1:0] acc_q;

   assign prod = $signed(a_i[k_q*DW +: DW]) * $signed(b_i[k_q*DW +: DW]);

   // start_i lands on the same edge the operands change, so term 0 is taken a cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q   <= '0;
         run_q <= 1'b0;
         vld_q <= 1'b0;
         acc_q <= '0;
      end else if (start_i) begin
         k_q   <= '0;
         run_q <= 1'b1;
         vld_q <= 1'b0;
         acc_q <= '0;
      end else if (run_q) begin
         acc_q <= acc_q + OW'(prod);
         if (k_q == len_i - CNT_W'(1)) begin
            run_q <= 1'b0;
            vld_q <= 1'b1;
         end else begin
            k_q <= k_q + CNT_W'(1);
         end
      end
   end

   assign sum_o   = acc_q;
   assign valid_o = vld_q;
`else
   always_comb begin
      sum_o = '0;
      prod  = '0;
      for (int k = 0; k < int'(MAXD); k++) begin
         prod = $signed(a_i[k*DW +: DW]) * $signed(b_i[k*DW +: DW]);
         if (k < int'(len_i)) begin
            sum_o = sum_o + OW'(prod);
         end
      end
   end

   assign valid_o = 1'b1;
`endif

endmodule

// File: rtl/mm_stream_param.sv
// Streaming C = A x B: loads A then B with row/column markers, checks legality, emits C row-major.
// Define MM_SERIAL_MAC_EN for a single-MAC dot unit (colsA cycles per result).
module mm_stream_param
   import mm_pkg::*;
#(
   parameter int unsigned DW   = 8,
   parameter int unsigned MAXD = 4,
   parameter int unsigned OW   = 2*DW + $clog2(MAXD) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          col_end,
   input  logic          row_end,
   output logic          chk_valid,
   output logic          is_legal,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          change_row,
   output logic          busy
);

   localparam int unsigned CNT_W = dim_w(MAXD);
   localparam int unsigned IDX_W = (MAXD > 1) ? $clog2(MAXD) : 1;
   localparam logic [CNT_W-1:0] MAXD_C = CNT_W'(MAXD);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   mm_state_e state_q, state_d;
   logic [CNT_W-1:0] row_q, row_d, col_q, col_d, ref_q, ref_d;
   logic [CNT_W-1:0] rows_a_q, rows_a_d, cols_a_q, cols_a_d;
   logic [CNT_W-1:0] rows_b_q, rows_b_d, cols_b_q, cols_b_d;
   logic [CNT_W-1:0] i_q, i_d, j_q, j_d;
   logic             ragged_q, ragged_d, oversize_q, oversize_d;

   logic signed [DW-1:0] a_q [MAXD][MAXD];
   logic signed [DW-1:0] b_q [MAXD][MAXD];

   logic             xfer, in_cell, wr_a, wr_b, hs, start, legal;
   logic [CNT_W-1:0] width, height;
   logic [RSN_W-1:0] reason;
   logic [MAXD*DW-1:0] a_row, b_col;
   logic signed [OW-1:0] dot;
   logic             dot_valid;

   // in_ready is forced low while rst is held so every output reads 0 during reset.
   assign in_ready = (state_q inside {StIdle, StLoadA, StLoadB}) && !rst;
   assign xfer     = in_valid && in_ready;
   assign in_cell  = (row_q < MAXD_C) && (col_q < MAXD_C);
   assign width    = (col_q == MAXD_C) ? MAXD_C : col_q + ONE_C;
   assign height   = (row_q == MAXD_C) ? MAXD_C : row_q + ONE_C;

   always_comb begin
      reason               = '0;
      reason[RSN_RAGGED]   = ragged_q;
      reason[RSN_OVERSIZE] = oversize_q;
      reason[RSN_MISMATCH] = (cols_a_q != rows_b_q);
   end
   assign legal = (reason == '0);

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      ref_d      = ref_q;
      rows_a_d   = rows_a_q;
      cols_a_d   = cols_a_q;
      rows_b_d   = rows_b_q;
      cols_b_d   = cols_b_q;
      i_d        = i_q;
      j_d        = j_q;
      ragged_d   = ragged_q;
      oversize_d = oversize_q;
      wr_a       = 1'b0;
      wr_b       = 1'b0;
      start      = 1'b0;
      unique case (state_q)
         StIdle, StLoadA, StLoadB: begin
            if (xfer) begin
               if (state_q == StIdle) begin
                  state_d    = StLoadA;
                  ragged_d   = 1'b0;
                  oversize_d = 1'b0;
               end
               if (in_cell) begin
                  wr_a = (state_q != StLoadB);
                  wr_b = (state_q == StLoadB);
               end else begin
                  oversize_d = 1'b1;
               end
               if (col_end) begin
                  col_d = '0;
                  if (row_q == '0) begin
                     ref_d = width;
                  end else if (width != ref_q) begin
                     ragged_d = 1'b1;
                  end
                  if (row_end) begin
                     row_d = '0;
                     if (state_q == StLoadB) begin
                        rows_b_d = height;
                        cols_b_d = (row_q == '0) ? width : ref_q;
                        state_d  = StCheck;
                     end else begin
                        rows_a_d = height;
                        cols_a_d = (row_q == '0) ? width : ref_q;
                        state_d  = StLoadB;
                     end
                  end else if (row_q != MAXD_C) begin
                     row_d = row_q + ONE_C;
                  end
               end else if (col_q != MAXD_C) begin
                  col_d = col_q + ONE_C;
               end
            end
         end
         StCheck: begin
            i_d = '0;
            j_d = '0;
            if (legal) begin
               state_d = StCompute;
               start   = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StCompute: begin
            if (hs) begin
               if (j_q == cols_b_q - ONE_C) begin
                  j_d = '0;
                  if (i_q == rows_a_q - ONE_C) begin
                     state_d = StIdle;
                  end else begin
                     i_d   = i_q + ONE_C;
                     start = 1'b1;
                  end
               end else begin
                  j_d   = j_q + ONE_C;
                  start = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         row_q      <= '0;
         col_q      <= '0;
         ref_q      <= '0;
         rows_a_q   <= '0;
         cols_a_q   <= '0;
         rows_b_q   <= '0;
         cols_b_q   <= '0;
         i_q        <= '0;
         j_q        <= '0;
         ragged_q   <= 1'b0;
         oversize_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         ref_q      <= ref_d;
         rows_a_q   <= rows_a_d;
         cols_a_q   <= cols_a_d;
         rows_b_q   <= rows_b_d;
         cols_b_q   <= cols_b_d;
         i_q        <= i_d;
         j_q        <= j_d;
         ragged_q   <= ragged_d;
         oversize_q <= oversize_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < int'(MAXD); r++) begin
            for (int c = 0; c < int'(MAXD); c++) begin
               a_q[r][c] <= '0;
               b_q[r][c] <= '0;
            end
         end
      end else begin
         if (wr_a) a_q[row_q[IDX_W-1:0]][col_q[IDX_W-1:0]] <= $signed(in_data);
         if (wr_b) b_q[row_q[IDX_W-1:0]][col_q[IDX_W-1:0]] <= $signed(in_data);
      end
   end

   always_comb begin
      a_row = '0;
      b_col = '0;
      for (int k = 0; k < int'(MAXD); k++) begin
         a_row[k*DW +: DW] = a_q[i_q[IDX_W-1:0]][k];
         b_col[k*DW +: DW] = b_q[k][j_q[IDX_W-1:0]];
      end
   end

   mm_dot_unit #(
      .DW   (DW),
      .MAXD (MAXD),
      .OW   (OW)
   ) u_dot (
`ifdef MM_SERIAL_MAC_EN
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
`endif
      .a_i     (a_row),
      .b_i     (b_col),
      .len_i   (cols_a_q),
      .sum_o   (dot),
      .valid_o (dot_valid)
   );

   assign chk_valid  = (state_q == StCheck);
   assign is_legal   = chk_valid && legal;
   assign busy       = chk_valid || (state_q == StCompute);
   assign out_valid  = (state_q == StCompute) && dot_valid;
   assign out_data   = out_valid ? dot : '0;
   assign change_row = out_valid && (j_q == cols_b_q - ONE_C);
   assign hs         = out_valid && out_ready;

   // A stalled result must not move until the sink takes it.
   assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(change_row)));

endmodule

// File: tb/tb_mm_stream_param.sv
// Randomized self-checking bench for mm_stream_param against a matrix-level reference model.
module tb_mm_stream_param;

   localparam int unsigned DW   = 8;
   localparam int unsigned MAXD = 4;
   localparam int unsigned OW   = 2*DW + $clog2(MAXD) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          col_end = 1'b0;
   logic          row_end = 1'b0;
   logic          chk_valid, is_legal, out_valid, change_row, busy;
   logic          out_ready = 1'b1;
   logic [OW-1:0] out_data;

   mm_stream_param #(.DW(DW), .MAXD(MAXD), .OW(OW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .col_end    (col_end),
      .row_end    (row_end),
      .chk_valid  (chk_valid),
      .is_legal   (is_legal),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .change_row (change_row),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int  a_v [8][8];
   int  b_v [8][8];
   int  a_nc [8];
   int  b_nc [8];
   int  a_nr, b_nr;
   int  exp_out_q [$];
   bit  exp_cr_q [$];
   bit  exp_chk_q [$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  hs_cnt = 0;
   int  or_mode = 0;
   int  pc = 0;
   bit  gaps = 0;
   bit  noise = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: legality and C straight from the matrix definitions.
   task automatic model_push();
      bit legal;
      longint s;
      legal = 1;
      if (a_nr > int'(MAXD) || b_nr > int'(MAXD)) legal = 0;
      for (int r = 0; r < a_nr; r++) if (a_nc[r] != a_nc[0] || a_nc[r] > int'(MAXD)) legal = 0;
      for (int r = 0; r < b_nr; r++) if (b_nc[r] != b_nc[0] || b_nc[r] > int'(MAXD)) legal = 0;
      if (a_nc[0] != b_nr) legal = 0;
      exp_chk_q.push_back(legal);
      if (legal) begin
         for (int i = 0; i < a_nr; i++) begin
            for (int j = 0; j < b_nc[0]; j++) begin
               s = 0;
               for (int k = 0; k < a_nc[0]; k++) s += a_v[i][k] * b_v[k][j];
               exp_out_q.push_back(int'(s));
               exp_cr_q.push_back(j == b_nc[0] - 1);
            end
         end
      end
   endtask

   task automatic send_mat(input bit is_b);
      int nr, nc, tries;
      bit acc;
      nr = is_b ? b_nr : a_nr;
      for (int r = 0; r < nr; r++) begin
         nc = is_b ? b_nc[r] : a_nc[r];
         for (int c = 0; c < nc; c++) begin
            acc = 0;
            tries = 0;
            while (!acc) begin
               @(posedge clk);
               #1;
               if (tries > 200) begin
                  check("in_ready_timeout", 0, 1);
                  in_valid = 0;
                  return;
               end
               tries++;
               in_valid = !gaps || ($urandom_range(0, 2) != 0);
               in_data  = DW'(is_b ? b_v[r][c] : a_v[r][c]);
               col_end  = (c == nc - 1);
               row_end  = col_end ? (r == nr - 1) : (noise && $urandom_range(0, 3) == 0);
               acc      = in_valid && in_ready;
            end
         end
      end
   endtask

   task automatic send_pair();
      send_mat(0);
      send_mat(1);
      @(posedge clk);
      #1;
      in_valid = 0;
      col_end  = 0;
      row_end  = 0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (t < 3000 && !(exp_out_q.size() == 0 && exp_chk_q.size() == 0 && !busy)) begin
         @(negedge clk);
         t++;
      end
      check("done_timeout", t < 3000, 1);
      check("leftover_results", exp_out_q.size(), 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
      exp_out_q.delete();
      exp_cr_q.delete();
      exp_chk_q.delete();
   endtask

   task automatic set_case1();
      a_nr = 2; a_nc[0] = 3; a_nc[1] = 3;
      a_v[0][0] = 1; a_v[0][1] = 2; a_v[0][2] = 3;
      a_v[1][0] = 4; a_v[1][1] = 5; a_v[1][2] = 6;
      b_nr = 3; b_nc[0] = 2; b_nc[1] = 2; b_nc[2] = 2;
      b_v[0][0] = 7;  b_v[0][1] = 8;
      b_v[1][0] = 9;  b_v[1][1] = 10;
      b_v[2][0] = 11; b_v[2][1] = 12;
   endtask

   task automatic fill(input bit is_b);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            if (is_b) b_v[r][c] = int'($urandom_range(0, 255)) - 128;
            else      a_v[r][c] = int'($urandom_range(0, 255)) - 128;
         end
   endtask

   task automatic rand_case();
      int c, bc;
      a_nr = $urandom_range(1, 4);
      c    = $urandom_range(1, 4);
      if ($urandom_range(0, 11) == 0) a_nr = 5;
      if ($urandom_range(0, 11) == 0) c = 5;
      for (int r = 0; r < 8; r++) a_nc[r] = c;
      if (a_nr > 1 && $urandom_range(0, 7) == 0) a_nc[a_nr-1] = (c == 1) ? 2 : c - 1;
      b_nr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : c;
      bc   = $urandom_range(1, 4);
      for (int r = 0; r < 8; r++) b_nc[r] = bc;
      fill(0);
      fill(1);
   endtask

   always @(posedge clk) begin
      #1;
      case (or_mode)
         1:       out_ready = (pc % 4 == 0) || (pc % 4 == 3);
         2:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = 1;
      endcase
      pc++;
   end

   // Compare process: legality strobe, result order, stall stability, end-of-product idle.
   bit     p_ov, p_or, p_cr, p_legal, idle_chk;
   longint p_data;
   always @(negedge clk) begin
      if (rst) begin
         p_ov = 0; p_or = 0; p_legal = 0; idle_chk = 0;
      end else begin
         if (idle_chk) begin
            check("busy_after_last", busy, 0);
            check("valid_after_last", out_valid, 0);
            idle_chk = 0;
         end
`ifndef MM_SERIAL_MAC_EN
         if (p_legal) check("first_valid_latency", out_valid, 1);
`endif
         p_legal = 0;
         if (chk_valid) begin
            check("chk_busy", busy, 1);
            if (exp_chk_q.size() == 0) check("unexpected_chk_valid", 1, 0);
            else begin
               bit e;
               e = exp_chk_q.pop_front();
               check("is_legal", is_legal, e);
               p_legal = e && is_legal;
            end
         end
         if (p_ov && !p_or) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", $signed(out_data), p_data);
            check("stall_change_row", change_row, p_cr);
         end
         if (out_valid && out_ready) begin
            if (exp_out_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
               int  ev;
               bit  ec;
               ev = exp_out_q.pop_front();
               ec = exp_cr_q.pop_front();
               check("c_data", $signed(out_data), ev);
               check("c_change_row", change_row, ec);
               check("c_busy", busy, 1);
               hs_cnt++;
               if (exp_out_q.size() == 0) idle_chk = 1;
            end
         end
         p_ov = out_valid; p_or = out_ready; p_cr = change_row; p_data = $signed(out_data);
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_change_row"}, change_row, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_chk_valid"}, chk_valid, 0);
      check({tag, "_is_legal"}, is_legal, 0);
      check({tag, "_in_ready"}, in_ready, 0);
   endtask

   initial begin
      int base, t;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1 rst = 0;

      // Case 1: known 2x3 * 3x2; model pinned to hand values.
      set_case1();
      model_push();
      check("model_c00", exp_out_q[0], 58);
      check("model_c01", exp_out_q[1], 64);
      check("model_c10", exp_out_q[2], 139);
      check("model_c11", exp_out_q[3], 154);
      check("model_cr01", exp_cr_q[1], 1);
      send_pair();
      wait_done();

      // Case 2: 1x1 extremes.
      a_nr = 1; a_nc[0] = 1; a_v[0][0] = -128;
      b_nr = 1; b_nc[0] = 1; b_v[0][0] = -128;
      model_push();
      check("model_1x1", exp_out_q[0], 16384);
      send_pair();
      wait_done();

      // Case 3: 2x2 by 3x1 mismatch, followed directly by a legal pair.
      a_nr = 2; a_nc[0] = 2; a_nc[1] = 2; fill(0);
      b_nr = 3; b_nc[0] = 1; b_nc[1] = 1; b_nc[2] = 1; fill(1);
      model_push();
      check("model_mismatch", exp_chk_q[0], 0);
      send_pair();
      wait_done();
      set_case1(); model_push(); send_pair(); wait_done();

      // Case 4: ragged A, then a 5-column row.
      a_nr = 2; a_nc[0] = 2; a_nc[1] = 3; fill(0);
      b_nr = 2; b_nc[0] = 2; b_nc[1] = 2; fill(1);
      model_push(); send_pair(); wait_done();
      a_nr = 1; a_nc[0] = 5; fill(0);
      b_nr = 5; for (int r = 0; r < 5; r++) b_nc[r] = 1; fill(1);
      model_push(); send_pair(); wait_done();

      // Case 5: case 1 with output back-pressure and input gaps.
      or_mode = 1; gaps = 1; noise = 1;
      set_case1(); model_push(); send_pair(); wait_done();
      or_mode = 0; gaps = 0; noise = 0;

      // Case 6: reset after the second result, then a clean reload.
      set_case1(); model_push();
      base = hs_cnt;
      send_pair();
      t = 0;
      while (hs_cnt < base + 2 && t < 500) begin
         @(posedge clk);
         t++;
      end
      check("reset_wait_timeout", t < 500, 1);
      #1 rst = 1;
      exp_out_q.delete(); exp_cr_q.delete(); exp_chk_q.delete();
      @(negedge clk);
      check_all_zero("midrst");
      @(posedge clk);
      #1 rst = 0;
      set_case1(); model_push(); send_pair(); wait_done();

      // Randomized pairs with random back-pressure.
      or_mode = 2; noise = 1;
      for (int n = 0; n < 40; n++) begin
         gaps = $urandom_range(0, 1);
         rand_case();
         model_push();
         send_pair();
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
